// File: rtl/graphics_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : graphics_pkg                                              |
// | Purpose  : Shared framebuffer geometry defaults and the writer FSM   |
// |            state encoding.                                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package graphics_pkg;

  localparam int H_RES_DEFAULT       = 320;
  localparam int V_RES_DEFAULT       = 180;
  localparam int ADDR_WIDTH_DEFAULT  = 16;
  localparam int COLOR_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_DRAW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_e;

endpackage : graphics_pkg
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pixel_fifo                                                |
// | Purpose  : Small synchronous FIFO for {colour, address} pixel words. |
// |            Full/empty are registered flags; a push into a full FIFO  |
// |            is dropped unless a pop happens in the same cycle.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pixel_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  dropped
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push, do_pop;

  // Next-state for pointers, occupancy and the registered flags
  always_comb begin
    do_pop   = pop && !empty_q;
    // a full FIFO still accepts when the head leaves in the same cycle
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control registers; reset empties the FIFO
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign dropped   = push && !do_push;

endmodule : pixel_fifo
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : framebuffer_writer                                        |
// | Purpose  : Clears the framebuffer, starts the rasterizer, clips and  |
// |            addresses incoming pixels through a 2-stage pipeline and  |
// |            drains them through a pixel FIFO to memory.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module framebuffer_writer
  import graphics_pkg::*;
#(
  parameter int                     COORD_WIDTH = 32,
  parameter int                     H_RES       = H_RES_DEFAULT,
  parameter int                     V_RES       = V_RES_DEFAULT,
  parameter int                     ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int                     COLOR_WIDTH = COLOR_WIDTH_DEFAULT,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  parameter int                     FIFO_DEPTH  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_frame,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic                   drawing,
  input  logic                   raster_done,
  input  logic [COLOR_WIDTH-1:0] color,
  input  logic                   mem_ready,
  output logic                   raster_start,
  output logic                   we,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [COLOR_WIDTH-1:0] wdata,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
  localparam logic [COORD_WIDTH-1:0] H_LIM     = COORD_WIDTH'(H_RES);
  localparam logic [COORD_WIDTH-1:0] V_LIM     = COORD_WIDTH'(V_RES);
  localparam int                     FIFO_W    = ADDR_WIDTH + COLOR_WIDTH;

  fb_state_e              state_q;
  logic [ADDR_WIDTH-1:0]  clear_addr_q;
  logic                   raster_start_q;
  logic                   frame_done_q;
  logic                   overflow_q;

  logic                   accepting;
  logic                   x_ok, y_ok;

  logic                   s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0]  s1_row_q, s1_row_d;
  logic [ADDR_WIDTH-1:0]  s1_col_q, s1_col_d;
  logic [COLOR_WIDTH-1:0] s1_color_q, s1_color_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0]  s2_addr_q, s2_addr_d;
  logic [COLOR_WIDTH-1:0] s2_color_q, s2_color_d;

  logic [FIFO_W-1:0]      fifo_head;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   fifo_drop;

  // Clip test and next values for both address pipeline stages
  always_comb begin
    accepting  = (state_q == ST_DRAW) || (state_q == ST_FLUSH);
    // a clear sign bit plus an unsigned bound is the signed 0 <= v < LIM test
    x_ok       = !x[COORD_WIDTH-1] && (x < H_LIM);
    y_ok       = !y[COORD_WIDTH-1] && (y < V_LIM);
    s1_valid_d = accepting && drawing && x_ok && y_ok;
    s1_row_d   = ADDR_WIDTH'(y) * ADDR_WIDTH'(H_RES);
    s1_col_d   = ADDR_WIDTH'(x);
    s1_color_d = color;
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_row_q + s1_col_q;
    s2_color_d = s1_color_q;
  end

  // Pipeline registers; reset discards any pixel in flight
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_color_q <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_color_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_color_q <= s1_color_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_color_q <= s2_color_d;
    end
  end

  assign fifo_pop = mem_ready && !fifo_empty;

  pixel_fifo #(
    .DATA_WIDTH (FIFO_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (s2_valid_q),
    .push_data ({s2_color_q, s2_addr_q}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .dropped   (fifo_drop)
  );

  // Frame sequencing FSM with registered pulse and sticky overflow outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      clear_addr_q   <= '0;
      raster_start_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      raster_start_q <= 1'b0;
      frame_done_q   <= 1'b0;
      if (fifo_drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_frame) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (mem_ready) begin
            if (clear_addr_q == LAST_ADDR) begin
              state_q        <= ST_DRAW;
              raster_start_q <= 1'b1;
            end else begin
              clear_addr_q <= clear_addr_q + 1'b1;
            end
          end
        end
        ST_DRAW: begin
          if (raster_done) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!s1_valid_q && !s2_valid_q && fifo_empty) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port: clear sweep in CLEAR, otherwise the FIFO head
  always_comb begin
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (state_q == ST_CLEAR) begin
      we    = 1'b1;
      addr  = clear_addr_q;
      wdata = CLEAR_COLOR;
    end else if (!fifo_empty) begin
      we    = 1'b1;
      addr  = fifo_head[ADDR_WIDTH-1:0];
      wdata = fifo_head[ADDR_WIDTH +: COLOR_WIDTH];
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign raster_start = raster_start_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

endmodule : framebuffer_writer
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_framebuffer_writer                                     |
// | Purpose  : Directed self-checking bench for framebuffer_writer on an |
// |            8x4 framebuffer with a 4-deep pixel FIFO.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_framebuffer_writer;
  import graphics_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_frame;
  logic [31:0] x, y;
  logic        drawing;
  logic        raster_done;
  logic [15:0] color;
  logic        mem_ready;
  logic        raster_start;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int raster_cnt = 0;
  int done_cnt   = 0;
  int r_cnt0, d_cnt0, bad;

  logic [15:0] log_addr [$];
  logic [15:0] log_data [$];
  logic [15:0] exp_addr [5];
  logic [15:0] exp_data [5];

  framebuffer_writer #(
    .COORD_WIDTH (32),
    .H_RES       (8),
    .V_RES       (4),
    .ADDR_WIDTH  (16),
    .COLOR_WIDTH (16),
    .CLEAR_COLOR (16'h0000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_frame  (start_frame),
    .x            (x),
    .y            (y),
    .drawing      (drawing),
    .raster_done  (raster_done),
    .color        (color),
    .mem_ready    (mem_ready),
    .raster_start (raster_start),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  always #5 clk_in = ~clk_in;

  // Record accepted writes and output pulses mid-cycle, away from the edge
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (we && mem_ready) begin
        log_addr.push_back(addr);
        log_data.push_back(wdata);
      end
      if (raster_start) raster_cnt++;
      if (frame_done)   done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; start_frame = 1'b0; x = '0; y = '0; drawing = 1'b0;
    raster_done = 1'b0; color = '0; mem_ready = 1'b0;
    tick();
    tick();

    // ---------------- reset state ----------------
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_raster_start", raster_start, 0);
    check("rst_frame_done", frame_done, 0);

    // ---------------- full clear ----------------
    rst_in = 1'b0; mem_ready = 1'b1; start_frame = 1'b1;
    log_addr.delete(); log_data.delete();
    tick();
    start_frame = 1'b0;
    check("clear_busy", busy, 1);
    for (int i = 0; i < 32; i++) begin
      check("clear_we", we, 1);
      check("clear_addr", addr, i);
      check("clear_rs_low", raster_start, 0);
      // drawing, raster_done and start_frame during CLEAR must be ignored
      if (i == 5) begin
        drawing = 1'b1; x = 32'd1; y = 32'd1; color = 16'hFFFF;
        raster_done = 1'b1; start_frame = 1'b1;
      end else begin
        drawing = 1'b0; raster_done = 1'b0; start_frame = 1'b0;
      end
      tick();
    end
    check("clear_raster_start", raster_start, 1);
    check("clear_state_draw", dut.state_q, ST_DRAW);
    check("clear_we_after", we, 0);
    bad = 0;
    if (log_addr.size() != 32) bad++;
    else for (int i = 0; i < 32; i++)
      if (log_addr[i] !== 16'(i) || log_data[i] !== 16'h0000) bad++;
    check("clear_log", bad, 0);
    tick();
    check("clear_rs_pulse_end", raster_start, 0);
    check("clear_rs_count", raster_cnt, 1);
    check("clear_no_stray_px", we, 0);

    // ---------------- single pixel, 3-cycle latency ----------------
    log_addr.delete(); log_data.delete();
    drawing = 1'b1; x = 32'd3; y = 32'd2; color = 16'hF800; start_frame = 1'b1;
    tick();
    drawing = 1'b0; start_frame = 1'b0;
    check("px_we_c1", we, 0);
    check("px_start_ignored", dut.state_q, ST_DRAW);
    tick();
    check("px_we_c2", we, 0);
    tick();
    check("px_we_c3", we, 1);
    check("px_addr", addr, 19);
    check("px_wdata", wdata, 16'hF800);
    tick();
    check("px_we_c4", we, 0);
    check("px_log_count", log_addr.size(), 1);

    // ---------------- clipping ----------------
    log_addr.delete(); log_data.delete();
    drawing = 1'b1; color = 16'h1234;
    x = 32'hFFFF_FFFF; y = 32'd0; tick();
    x = 32'd8;         y = 32'd0; tick();
    x = 32'd0;         y = 32'd4; tick();
    x = 32'd0;         y = 32'hFFFF_0000; tick();
    drawing = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("clip_we", we, 0);
      tick();
    end
    check("clip_log_count", log_addr.size(), 0);
    check("clip_overflow", overflow, 0);

    // ---------------- backpressure ----------------
    log_addr.delete(); log_data.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 3 && i <= 8) begin
        drawing = 1'b1; x = 32'(i - 3); y = 32'd1; color = 16'(16'h0A00 + i - 3);
      end else begin
        drawing = 1'b0;
      end
      tick();
    end
    drawing = 1'b0; mem_ready = 1'b1;
    check("bp_overflow", overflow, 1);
    check("bp_no_write_stalled", log_addr.size(), 0);
    check("bp_we_full", we, 1);
    repeat (7) tick();
    exp_addr = '{16'd8, 16'd9, 16'd10, 16'd11, 16'd13};
    exp_data = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A05};
    check("bp_log_count", log_addr.size(), 5);
    bad = 0;
    if (log_addr.size() == 5)
      for (int i = 0; i < 5; i++)
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) bad++;
    check("bp_log_order", bad, 0);
    check("bp_we_drained", we, 0);

    // ---------------- end of frame with 2 queued pixels ----------------
    log_addr.delete(); log_data.delete();
    mem_ready = 1'b0;
    drawing = 1'b1; x = 32'd7; y = 32'd3; color = 16'h07E0; tick();
    x = 32'd0; y = 32'd3; color = 16'h001F; tick();
    drawing = 1'b0;
    tick();
    tick();
    check("eof_we_queued", we, 1);
    check("eof_fifo_count", dut.u_fifo.count_q, 2);
    raster_done = 1'b1;
    tick();
    raster_done = 1'b0; mem_ready = 1'b1;
    check("eof_state_flush", dut.state_q, ST_FLUSH);
    check("eof_busy_flush", busy, 1);
    check("eof_fd_early", frame_done, 0);
    tick();
    tick();
    check("eof_fd_not_yet", frame_done, 0);
    tick();
    check("eof_frame_done", frame_done, 1);
    check("eof_busy_done", busy, 1);
    tick();
    check("eof_fd_pulse_end", frame_done, 0);
    check("eof_busy_low", busy, 0);
    check("eof_state_idle", dut.state_q, ST_IDLE);
    check("eof_done_count", done_cnt, 1);
    bad = 0;
    if (log_addr.size() != 2) bad++;
    else begin
      if (log_addr[0] !== 16'd31 || log_data[0] !== 16'h07E0) bad++;
      if (log_addr[1] !== 16'd24 || log_data[1] !== 16'h001F) bad++;
    end
    check("eof_log", bad, 0);

    // ---------------- reset mid-clear ----------------
    r_cnt0 = raster_cnt; d_cnt0 = done_cnt;
    start_frame = 1'b1; mem_ready = 1'b1;
    tick();
    start_frame = 1'b0;
    check("rmc_overflow_cleared", overflow, 0);
    repeat (10) tick();
    check("rmc_addr10", addr, 10);
    check("rmc_we_clear", we, 1);
    rst_in = 1'b1; start_frame = 1'b1;
    tick();
    rst_in = 1'b0; start_frame = 1'b0;
    check("rmc_we", we, 0);
    check("rmc_busy", busy, 0);
    repeat (40) tick();
    check("rmc_no_raster_start", raster_cnt, r_cnt0);
    check("rmc_no_frame_done", done_cnt, d_cnt0);
    check("rmc_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_framebuffer_writer
`default_nettype wire

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 The block SHALL have parameter COORD_WIDTH, default 32, giving the width of the incoming pixel coordinates.
REQ-002 The block SHALL have parameter H_RES, default 320, giving the framebuffer width in pixels.
REQ-003 The block SHALL have parameter V_RES, default 180, giving the framebuffer height in pixels.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 16, giving the framebuffer address width; H_RES*V_RES SHALL be at most 2^ADDR_WIDTH.
REQ-005 The block SHALL have parameter COLOR_WIDTH, default 16, giving the pixel word width.
REQ-006 The block SHALL have parameter CLEAR_COLOR, default 0, giving the word written during clear.
REQ-007 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two, giving the pixel FIFO depth.
REQ-008 The block SHALL use one clock, clk_in, and a synchronous active-high reset, rst_in, with the ports listed below (clock and reset first):
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start_frame  input  1  one-cycle pulse; begins clear, then draw.
- x, y  input  COORD_WIDTH  rasterizer pixel coordinates, two's complement.
- drawing  input  1  x/y valid this cycle.
- raster_done  input  1  one-cycle pulse; rasterizer finished.
- color  input  COLOR_WIDTH  fill colour, sampled with drawing.
- mem_ready  input  1  memory accepts a write this cycle.
- raster_start  output  1  one-cycle pulse to the rasterizer start.
- we  output  1  write strobe.
- addr  output  ADDR_WIDTH  write address.
- wdata  output  COLOR_WIDTH  write data.
- busy  output  1  state is not IDLE.
- frame_done  output  1  one-cycle pulse at end of frame.
- overflow  output  1  sticky; a pixel was dropped because the FIFO was full.

Function
REQ-009 The FSM SHALL have the states IDLE, CLEAR, DRAW, FLUSH and DONE.
REQ-010 In IDLE, start_frame SHALL move the FSM to CLEAR, load clear_addr with 0, and clear overflow.
REQ-011 CLEAR SHALL drive we=1, addr=clear_addr and wdata=CLEAR_COLOR; clear_addr SHALL increment only on cycles with mem_ready=1.
REQ-012 When the write to addr H_RES*V_RES-1 is accepted, the FSM SHALL go to DRAW and pulse raster_start for exactly one cycle on that transition.
REQ-013 In DRAW and FLUSH, a pixel with drawing=1 SHALL be clipped and discarded unless 0<=x<H_RES and 0<=y<V_RES, compared as signed values.
REQ-014 A pixel that passes the clip SHALL have addr = y*H_RES + x computed in a 2-stage pipeline (stage 1 registers y*H_RES and x; stage 2 registers the sum) and then be pushed to the FIFO with its colour.
REQ-015 FIFO pop SHALL occur when it is non-empty and mem_ready=1; we SHALL equal FIFO non-empty, with addr and wdata taken from the FIFO head.
REQ-016 A push to a full FIFO SHALL drop the pixel and set overflow; a simultaneous push and pop on a full FIFO SHALL succeed.
REQ-017 raster_done in DRAW SHALL move the FSM to FLUSH.
REQ-018 FLUSH SHALL go to DONE once both pipeline stages are empty and the FIFO is empty.
REQ-019 DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-020 start_frame outside IDLE SHALL be ignored.
REQ-021 drawing or raster_done in IDLE or CLEAR SHALL be ignored.
REQ-022 Latency from accepted drawing to we SHALL be 3 cycles when the FIFO is empty and mem_ready=1.
REQ-023 Throughput SHALL be 1 pixel per cycle while mem_ready=1.

Reset
REQ-024 On rst_in, state SHALL be IDLE; we, raster_start, frame_done, busy and overflow SHALL be 0; the FIFO and pipeline SHALL be emptied; addr and wdata SHALL be 0.
REQ-025 Reset mid-frame SHALL abandon the frame without emitting frame_done.
REQ-026 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-027 H_RES, V_RES, ADDR_WIDTH and COLOR_WIDTH defaults, together with the FSM state enum, SHALL live in the shared package graphics_pkg.
REQ-028 The FIFO SHALL be a separate sub-module, pixel_fifo, parameterised by data width and depth, with a registered full/empty flag.

Verification
REQ-029 The bench SHALL cover full clear: start_frame with H_RES=8, V_RES=4, mem_ready=1 -> 32 writes of 0 to addresses 0..31 in consecutive cycles, then raster_start pulses once.
REQ-030 The bench SHALL cover pixel write: in DRAW, x=3, y=2, colour 16'hF800 -> we with addr=19 and wdata=16'hF800 exactly 3 cycles later.
REQ-031 The bench SHALL cover clipping: x=-1, x=8, y=4 and y=32'hFFFF0000 -> no write issued, overflow stays 0.
REQ-032 The bench SHALL cover backpressure: mem_ready=0 for 10 cycles while 6 valid pixels arrive with FIFO_DEPTH=4 -> overflow=1, exactly 4 plus the in-pipeline pixels written in order after mem_ready returns, no duplicates.
REQ-033 The bench SHALL cover end of frame: raster_done while the FIFO holds 2 entries -> both written, then frame_done pulses once, busy falls, and the FSM is in IDLE.
REQ-034 The bench SHALL cover reset mid-clear: rst_in at clear_addr=10 -> next cycle we=0 and busy=0, no raster_start and no frame_done.
